// File: rtl/tug_of_war_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tug_of_war_ctrl_pkg
// Brief    : LED-mux control codes, score constants and sizing helpers shared
//            by the tug-of-war game sequencer and the LED multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package tug_of_war_ctrl_pkg;

    localparam logic [1:0] LED_ALL      = 2'd0;
    localparam logic [1:0] LED_NONE     = 2'd1;
    localparam logic [1:0] LED_SCORE    = 2'd3;
    localparam logic [6:0] SCORE_CENTRE = 7'b0001000;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b10;
    localparam logic [1:0] WIN_RIGHT = 2'b01;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Never returns zero so a counter for a count of 1 still has a bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tug_of_war_ctrl_btn_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_edge
// Brief    : Rising-edge detector for one debounced, synchronous button.
// Revision : 1.0 - initial release
// ============================================================================
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    logic r_btn_q;

    // Resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_q <= 1'b1;
        end else begin
            r_btn_q <= i_btn;
        end
    end

    assign o_press = i_btn & ~r_btn_q;

endmodule
`default_nettype wire

// File: rtl/tug_of_war_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tug_of_war_ctrl
// Brief    : Tug-of-war game sequencer: start banner, play, win flash, final
//            position hold, restart. Drives LED mux control and score marker.
// Revision : 1.0 - initial release
// ============================================================================
module tug_of_war_ctrl
    import tug_of_war_ctrl_pkg::*;
#(
    parameter int START_CYCLES = 25_000_000,
    parameter int FLASH_CYCLES = 5_000_000,
    parameter int FLASH_PHASES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_l,
    input  logic       btn_r,
    output logic [1:0] leds_ctrl,
    output logic [6:0] score,
    output logic [1:0] winner
);

    localparam int c_cnt_w = clog2_min1(max_int(START_CYCLES, FLASH_CYCLES));
    localparam int c_ph_w  = clog2_min1(FLASH_PHASES);

    localparam logic [c_cnt_w-1:0] c_start_last = c_cnt_w'(START_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_flash_last = c_cnt_w'(FLASH_CYCLES - 1);
    localparam logic [c_ph_w-1:0]  c_ph_last    = c_ph_w'(FLASH_PHASES - 1);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_PLAY  = 2'd1,
        S_WIN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_leds, w_leds_nxt;
    logic [6:0]         r_score, w_score_nxt;
    logic [1:0]         r_winner, w_winner_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic [c_ph_w-1:0]  r_ph, w_ph_nxt;
    logic               w_press_l, w_press_r;

    btn_edge u_edge_l (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_l),
        .o_press (w_press_l)
    );

    btn_edge u_edge_r (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_r),
        .o_press (w_press_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_START;
            r_leds   <= LED_ALL;
            r_score  <= SCORE_CENTRE;
            r_winner <= WIN_NONE;
            r_cnt    <= '0;
            r_ph     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_leds   <= w_leds_nxt;
            r_score  <= w_score_nxt;
            r_winner <= w_winner_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ph     <= w_ph_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_leds_nxt   = r_leds;
        w_score_nxt  = r_score;
        w_winner_nxt = r_winner;
        w_cnt_nxt    = r_cnt;
        w_ph_nxt     = r_ph;

        case (r_state)
            S_START: begin
                w_leds_nxt   = LED_ALL;
                w_score_nxt  = SCORE_CENTRE;
                w_winner_nxt = WIN_NONE;
                if (r_cnt == c_start_last) begin
                    w_state_nxt = S_PLAY;
                    w_leds_nxt  = LED_SCORE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end

            S_PLAY: begin
                w_leds_nxt = LED_SCORE;
                // Simultaneous presses cancel; reaching an end starts the flash.
                if (w_press_l && !w_press_r) begin
                    w_score_nxt = r_score << 1;
                    if (w_score_nxt[6]) begin
                        w_winner_nxt = WIN_LEFT;
                        w_state_nxt  = S_WIN;
                        w_leds_nxt   = LED_ALL;
                        w_cnt_nxt    = '0;
                        w_ph_nxt     = '0;
                    end
                end else if (w_press_r && !w_press_l) begin
                    w_score_nxt = r_score >> 1;
                    if (w_score_nxt[0]) begin
                        w_winner_nxt = WIN_RIGHT;
                        w_state_nxt  = S_WIN;
                        w_leds_nxt   = LED_ALL;
                        w_cnt_nxt    = '0;
                        w_ph_nxt     = '0;
                    end
                end
            end

            S_WIN: begin
                if (r_cnt == c_flash_last) begin
                    w_cnt_nxt = '0;
                    if (r_ph == c_ph_last) begin
                        w_state_nxt = S_DONE;
                        w_leds_nxt  = LED_SCORE;
                        w_ph_nxt    = '0;
                    end else begin
                        w_ph_nxt   = r_ph + c_ph_w'(1);
                        w_leds_nxt = (r_leds == LED_ALL) ? LED_NONE : LED_ALL;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end

            S_DONE: begin
                w_leds_nxt = LED_SCORE;
                if (btn_l && btn_r) begin
                    w_state_nxt  = S_START;
                    w_leds_nxt   = LED_ALL;
                    w_score_nxt  = SCORE_CENTRE;
                    w_winner_nxt = WIN_NONE;
                    w_cnt_nxt    = '0;
                    w_ph_nxt     = '0;
                end
            end

            default: begin
                w_state_nxt  = S_START;
                w_leds_nxt   = LED_ALL;
                w_score_nxt  = SCORE_CENTRE;
                w_winner_nxt = WIN_NONE;
                w_cnt_nxt    = '0;
                w_ph_nxt     = '0;
            end
        endcase
    end

    assign leds_ctrl = r_leds;
    assign score     = r_score;
    assign winner    = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_tug_of_war_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tug_of_war_ctrl
// Brief    : Scoreboard bench for tug_of_war_ctrl against a timeline-based
//            reference model of the game rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tug_of_war_ctrl;

    localparam int c_start  = 4;
    localparam int c_flash  = 3;
    localparam int c_phases = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_l;
    logic       btn_r;
    logic [1:0] leds_ctrl;
    logic [6:0] score;
    logic [1:0] winner;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    logic [10:0] exp_q[$];

    // Model: game mode, marker position 0 (right end) .. 6 (left end),
    // who won, and time spent in the current mode.
    int m_mode;     // 0 banner, 1 play, 2 flash, 3 hold
    int m_pos;
    int m_who;      // 0 none, 1 left, 2 right
    int m_t;
    bit m_prev_l;
    bit m_prev_r;

    tug_of_war_ctrl #(
        .START_CYCLES (c_start),
        .FLASH_CYCLES (c_flash),
        .FLASH_PHASES (c_phases)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_l     (btn_l),
        .btn_r     (btn_r),
        .leds_ctrl (leds_ctrl),
        .score     (score),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit r, input bit bl, input bit br);
        bit pl, pr;
        pl = bl && !m_prev_l;
        pr = br && !m_prev_r;
        m_prev_l = r ? 1'b1 : bl;
        m_prev_r = r ? 1'b1 : br;
        if (r) begin
            m_mode = 0; m_pos = 3; m_who = 0; m_t = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (m_t == c_start - 1) begin m_mode = 1; m_t = 0; end
                    else m_t++;
                end
                1: begin
                    if (pl && !pr) begin
                        m_pos++;
                        if (m_pos == 6) begin m_who = 1; m_mode = 2; m_t = 0; end
                    end else if (pr && !pl) begin
                        m_pos--;
                        if (m_pos == 0) begin m_who = 2; m_mode = 2; m_t = 0; end
                    end
                end
                2: begin
                    m_t++;
                    if (m_t == c_flash * c_phases) begin m_mode = 3; m_t = 0; end
                end
                default: begin
                    if (bl && br) begin m_mode = 0; m_pos = 3; m_who = 0; m_t = 0; end
                end
            endcase
        end
    endtask

    function automatic logic [10:0] model_out();
        logic [1:0] l;
        logic [6:0] s;
        logic [1:0] w;
        case (m_mode)
            0:       l = 2'd0;
            2:       l = ((m_t / c_flash) % 2 == 0) ? 2'd0 : 2'd1;
            default: l = 2'd3;
        endcase
        s = 7'(1) << m_pos;
        w = (m_who == 1) ? 2'b10 : (m_who == 2) ? 2'b01 : 2'b00;
        return {l, s, w};
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show after the edge.
    task automatic cyc(input bit r, input bit bl, input bit br);
        rst   = r;
        btn_l = bl;
        btn_r = br;
        model_step(r, bl, br);
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_out(input string tag, input logic [1:0] e_l,
                             input logic [6:0] e_s, input logic [1:0] e_w);
        total++;
        if ({leds_ctrl, score, winner} !== {e_l, e_s, e_w}) begin
            bad++;
            $display("FAIL %s got leds=%0d score=%b win=%b exp leds=%0d score=%b win=%b",
                     tag, leds_ctrl, score, winner, e_l, e_s, e_w);
        end
    endtask

    initial begin : monitor
        logic [10:0] e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({leds_ctrl, score, winner} !== e) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got leds=%0d score=%b win=%b exp leds=%0d score=%b win=%b",
                             cycle, leds_ctrl, score, winner, e[10:9], e[8:2], e[1:0]);
                end
            end
        end
    end

    initial begin : stim
        m_prev_l = 1'b1;
        m_prev_r = 1'b1;
        m_mode = 0; m_pos = 3; m_who = 0; m_t = 0;

        // Reset with left held, held level must not move the marker.
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        check_out("reset_state", 2'd0, 7'b0001000, 2'b00);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0);
        check_out("start_wait_expired", 2'd3, 7'b0001000, 2'b00);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0);
        idle(1);

        // Three left pulses to the left end.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            idle(1);
        end

        // Flash with left presses scattered in, then hold.
        for (int i = 0; i < 14; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        idle(5);

        // Simultaneous press cancels; a later right press moves.
        cyc(1'b0, 1'b1, 1'b1);
        idle(2);
        cyc(1'b0, 1'b0, 1'b1);
        idle(2);

        // Walk to the left end, then reset inside the second flash phase.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            idle(1);
        end
        idle(4);
        cyc(1'b1, 1'b0, 1'b0);
        idle(8);

        // Randomized play with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 299) == 0),
                1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 2) == 0));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
